// File: rtl/cmp_stats_pkg.sv
// Shared definitions for the comparator statistics accumulator:
// window FSM state encoding and the two-bit verdict codes.
package cmp_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [1:0] VERDICT_TIE = 2'b00;
    localparam logic [1:0] VERDICT_GR  = 2'b01;
    localparam logic [1:0] VERDICT_LE  = 2'b10;
    localparam logic [1:0] VERDICT_EQ  = 2'b11;

endpackage

// File: rtl/cmp_stats_verdict.sv
// Combinational verdict decode: names the class whose count is strictly
// greatest, or TIE when no single class leads.
module cmp_stats_verdict
    import cmp_stats_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] gr_cnt,
    input  logic [CNT_W-1:0] le_cnt,
    input  logic [CNT_W-1:0] eq_cnt,
    output logic [1:0]       verdict
);

    always_comb begin
        verdict = VERDICT_TIE;
        if (gr_cnt > le_cnt && gr_cnt > eq_cnt) begin
            verdict = VERDICT_GR;
        end else if (le_cnt > gr_cnt && le_cnt > eq_cnt) begin
            verdict = VERDICT_LE;
        end else if (eq_cnt > gr_cnt && eq_cnt > le_cnt) begin
            verdict = VERDICT_EQ;
        end
    end

endmodule

// File: rtl/cmp_stats_accum.sv
// Accumulates WIN comparator results into per-class counts and holds a report
// until taken. Optional one-hot flag checking is enabled by CMP_STATS_ERRCHK_EN.
module cmp_stats_accum
    import cmp_stats_pkg::*;
#(
    parameter  int WIN   = 8,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_gr,
    input  logic             in_le,
    input  logic             in_eq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gr_cnt,
    output logic [CNT_W-1:0] le_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [1:0]       verdict,
    output logic             err
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_cnt;
    logic             accept, legal, take, last, drain;
    logic             is_gr, is_le, is_eq;
    logic [1:0]       verdict_raw;

    assign in_ready  = (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready && !clr;
    assign drain     = out_valid && out_ready;

    assign is_gr = in_gr;
    assign is_le = !in_gr && in_le;
    assign is_eq = !in_gr && !in_le;

`ifdef CMP_STATS_ERRCHK_EN
    assign legal = ({in_gr, in_le, in_eq} == 3'b100) ||
                   ({in_gr, in_le, in_eq} == 3'b010) ||
                   ({in_gr, in_le, in_eq} == 3'b001);

    // Sticky until reset or clr; an illegal sample never advances the window.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end
    end
`else
    logic eq_flag_unused;
    assign eq_flag_unused = in_eq;
    assign legal          = 1'b1;
    assign err            = 1'b0;
`endif

    assign take = accept && legal;
    assign last = take && (n_cnt == CNT_W'(WIN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take)      state_nx = last ? ST_HOLD : ST_ACC;
            ST_ACC:  if (last)      state_nx = ST_HOLD;
            ST_HOLD: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
        if (clr) begin
            state_nx = ST_IDLE;
        end
    end

    // The total counter stops at WIN because the window closes there, so no class count can wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clr || drain) begin
            n_cnt  <= '0;
            gr_cnt <= '0;
            le_cnt <= '0;
            eq_cnt <= '0;
        end else if (take) begin
            n_cnt  <= n_cnt  + CNT_W'(1);
            gr_cnt <= gr_cnt + {{(CNT_W-1){1'b0}}, is_gr};
            le_cnt <= le_cnt + {{(CNT_W-1){1'b0}}, is_le};
            eq_cnt <= eq_cnt + {{(CNT_W-1){1'b0}}, is_eq};
        end
    end

    cmp_stats_verdict #(
        .CNT_W (CNT_W)
    ) u_verdict (
        .gr_cnt  (gr_cnt),
        .le_cnt  (le_cnt),
        .eq_cnt  (eq_cnt),
        .verdict (verdict_raw)
    );

    assign verdict = out_valid ? verdict_raw : VERDICT_TIE;

endmodule

// File: tb/tb_cmp_stats_accum.sv
// Directed bench for cmp_stats_accum (WIN=8); expectations adapt to
// whether CMP_STATS_ERRCHK_EN is defined.
module tb_cmp_stats_accum;

    localparam int WIN   = 8;
    localparam int CNT_W = $clog2(WIN + 1);

    logic             clk = 1'b0;
    logic             rst_n, clr, in_valid, in_gr, in_le, in_eq, out_ready;
    logic             in_ready, out_valid, err;
    logic [CNT_W-1:0] gr_cnt, le_cnt, eq_cnt;
    logic [1:0]       verdict;

    int n_vec  = 0;
    int n_miss = 0;

    cmp_stats_accum #(.WIN(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gr     (in_gr),
        .in_le     (in_le),
        .in_eq     (in_eq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gr_cnt    (gr_cnt),
        .le_cnt    (le_cnt),
        .eq_cnt    (eq_cnt),
        .verdict   (verdict),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic g, input logic l, input logic e);
        in_valid = 1'b1;
        in_gr    = g;
        in_le    = l;
        in_eq    = e;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int g, input int l, input int e);
        chk({tag, "_gr"}, 32'(gr_cnt), g);
        chk({tag, "_le"}, 32'(le_cnt), l);
        chk({tag, "_eq"}, 32'(eq_cnt), e);
    endtask

    logic errchk;

    initial begin
`ifdef CMP_STATS_ERRCHK_EN
        errchk = 1'b1;
`else
        errchk = 1'b0;
`endif
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_gr = 1'b0; in_le = 1'b0; in_eq = 1'b0; out_ready = 1'b1;

        // Reset
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_verdict",   32'(verdict),   0);
        chk("rst_err",       32'(err),       0);
        check_counts("rst", 0, 0, 0);

        // GR window: 5 gr, 2 le, 1 eq
        for (int i = 0; i < 5; i++) send(1, 0, 0);
        send(0, 1, 0);
        send(0, 1, 0);
        chk("gr_no_early_valid", 32'(out_valid), 0);
        send(0, 0, 1);
        chk("gr_out_valid", 32'(out_valid), 1);
        chk("gr_in_ready",  32'(in_ready),  0);
        chk("gr_verdict",   32'(verdict),   1);
        check_counts("gr", 5, 2, 1);
        tick();
        chk("gr_after_in_ready",  32'(in_ready),  1);
        chk("gr_after_out_valid", 32'(out_valid), 0);
        check_counts("gr_after", 0, 0, 0);

        // Tie with backpressure; in_valid during HOLD must be ignored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 0, 0);
        for (int i = 0; i < 4; i++) send(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("tie_out_valid", 32'(out_valid), 1);
            chk("tie_in_ready",  32'(in_ready),  0);
            chk("tie_verdict",   32'(verdict),   0);
            check_counts("tie", 4, 4, 0);
            send(1, 0, 0);
        end
        check_counts("tie_held", 4, 4, 0);
        out_ready = 1'b1;
        tick();
        chk("tie_drained", 32'(out_valid), 0);
        check_counts("tie_drained", 0, 0, 0);

        // EQ window
        for (int i = 0; i < 8; i++) send(0, 0, 1);
        chk("eq_out_valid", 32'(out_valid), 1);
        chk("eq_verdict",   32'(verdict),   3);
        check_counts("eq", 0, 0, 8);
        tick();

        // Illegal sample gr=le=1
        send(1, 1, 0);
        chk("ill_err", 32'(err), 32'(errchk));
        for (int i = 0; i < 7; i++) send(1, 0, 0);
        chk("ill_out_valid_7", 32'(out_valid), errchk ? 0 : 1);
        if (errchk) send(1, 0, 0);
        chk("ill_out_valid", 32'(out_valid), 1);
        chk("ill_verdict",   32'(verdict),   1);
        check_counts("ill", 8, 0, 0);
        chk("ill_err_sticky", 32'(err), 32'(errchk));
        tick();

        // Mid-window clr with a coincident sample
        for (int i = 0; i < 3; i++) send(1, 0, 0);
        chk("clr_pre_verdict", 32'(verdict), 0);
        check_counts("clr_pre", 3, 0, 0);
        clr = 1'b1;
        send(1, 0, 0);
        clr = 1'b0;
        chk("clr_err",       32'(err),       0);
        chk("clr_in_ready",  32'(in_ready),  1);
        chk("clr_out_valid", 32'(out_valid), 0);
        check_counts("clr", 0, 0, 0);
        for (int i = 0; i < 7; i++) send(0, 1, 0);
        chk("clr_win_7", 32'(out_valid), 0);
        send(0, 1, 0);
        chk("clr_win_valid",   32'(out_valid), 1);
        chk("clr_win_verdict", 32'(verdict),   2);
        check_counts("clr_win", 0, 8, 0);
        tick();

        // Reset mid-window discards the partial window
        for (int i = 0; i < 5; i++) send(0, 0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_counts("rst_mid", 0, 0, 0);
        for (int i = 0; i < 7; i++) send(1, 0, 0);
        chk("rst_mid_no_report", 32'(out_valid), 0);
        send(1, 0, 0);
        chk("rst_mid_report", 32'(out_valid), 1);
        check_counts("rst_mid_win", 8, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cmp_stats_accum.md
CMP_STATS_ACCUM -- requirements
Module: cmp_stats_accum

Interface
REQ-001 SHALL have parameter WIN, default 8, range 2..255: number of accepted comparator results per reporting window.
REQ-002 SHALL have derived localparam CNT_W = $clog2(WIN+1): counter and count-output width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous window abort and clear.
REQ-006 SHALL have port in_valid  input  1  comparator result present this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a result this cycle.
REQ-008 SHALL have ports in_gr, in_le, in_eq  input  1 each  comparator greater, less and equal flags.
REQ-009 SHALL have port out_valid  output  1  window report held.
REQ-010 SHALL have port out_ready  input  1  consumer takes the report.
REQ-011 SHALL have ports gr_cnt, le_cnt, eq_cnt  output  CNT_W each  per-class counts for the window.
REQ-012 SHALL have port verdict  output  2  00 TIE, 01 GR, 10 LE, 11 EQ.
REQ-013 SHALL have port err  output  1  sticky illegal-flag indicator.

Function
REQ-014 SHALL implement states IDLE, ACC and HOLD; in_ready=1 in IDLE and ACC and 0 in HOLD.
REQ-015 SHALL accept a sample when in_valid and in_ready are both 1; in_valid while in_ready=0 SHALL be ignored.
REQ-016 SHALL move IDLE->ACC on the first accepted sample, and ACC->HOLD on the cycle after the WIN-th accepted sample.
REQ-017 SHALL classify each accepted sample by priority: gr, then le, otherwise eq, unless REQ-027 applies.
REQ-018 SHALL raise out_valid one cycle after the WIN-th acceptance, with counts that include that sample; gr_cnt+le_cnt+eq_cnt SHALL equal WIN.
REQ-019 SHALL hold out_valid, the counts and verdict stable until out_valid and out_ready are both 1; HOLD SHALL then go to IDLE with counts zeroed, and in_ready SHALL rise the following cycle (no same-cycle bypass).
REQ-020 SHALL set verdict GR/LE/EQ only when that count is strictly greatest, otherwise TIE; verdict SHALL be 00 whenever out_valid=0.
REQ-021 SHALL make counters saturate-free by construction: no count exceeds WIN, and there is no wrap.
REQ-022 SHALL give clr priority over any acceptance or report handshake in the same cycle: state IDLE, counts 0, out_valid 0, err 0, and the coincident sample dropped.

Reset
REQ-023 SHALL, with rst_n=0 at a clock edge, enter IDLE and drive out_valid=0, in_ready=1 on release, counts=0, verdict=00, err=0.
REQ-024 SHALL treat reset mid-window or during HOLD like clr: partial window discarded, no report emitted.

Configuration
REQ-025 SHALL compile the error check in only when macro CMP_STATS_ERRCHK_EN is defined.
REQ-026 SHALL, without CMP_STATS_ERRCHK_EN, tie err to 0 and classify every accepted sample per REQ-017.
REQ-027 SHALL, with CMP_STATS_ERRCHK_EN, treat an accepted sample whose flags are not exactly one-hot as illegal: err set sticky (cleared only by reset or clr), sample not counted and not advancing the window.

Structure
REQ-028 SHALL place the state encoding and the verdict codes (TIE, GR, LE, EQ) in shared package cmp_stats_pkg.
REQ-029 SHALL implement the verdict decode as combinational sub-module cmp_stats_verdict (inputs: three counts; output: verdict).

Verification
REQ-030 SHALL cover reset: rst_n=0 for 2 cycles -> all outputs 0, in_ready=1 after release.
REQ-031 SHALL cover a GR window with WIN=8, out_ready=1: 5 gr, 2 le, 1 eq -> out_valid one cycle after the 8th sample, counts 5/2/1, verdict 01, in_ready=1 the next cycle.
REQ-032 SHALL cover a tie with backpressure: 4 gr and 4 le, out_ready=0 for 3 cycles -> out_valid held, verdict 00, in_ready=0, in_valid ignored, counts stable.
REQ-033 SHALL cover an EQ window: 8 eq samples -> eq_cnt=8, verdict 11.
REQ-034 SHALL cover an illegal sample with gr=le=1: with the macro, err=1 and a report only after 8 further legal samples; without the macro, err=0 and the sample counts as gr.
REQ-035 SHALL cover mid-window clr: clr with in_valid after 3 samples -> counts 0, IDLE, and the next 8 samples form one complete window.
